// File: rtl/dcache_direct_mapped_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// slave = cache view; master = CPU plus main-memory view.
interface dcache_direct_mapped_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// 8-entry direct-mapped, write-back, write-allocate byte cache over a
// 32-bit-block memory, with saturating hit/miss statistics.
module dcache_direct_mapped #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dcache_direct_mapped_if.slave bus,
  output logic [CNT_W-1:0]      HIT_COUNT,
  output logic [CNT_W-1:0]      MISS_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UPDATE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        valid_q, dirty_q;
  logic [2:0]        tag_q  [8];
  logic [31:0]       data_q [8];
  logic [7:0]        rdata_q;
  logic [5:0]        miss_addr_q;
  logic              replay_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic [2:0]  idx, mi;
  logic [1:0]  off;
  logic [31:0] blk;
  logic [7:0]  sel_byte;
  logic        req, hit, rd_hit, wr_hit, miss, fill_done;
  logic        mem_read, mem_write, busy;
  logic [5:0]  mem_addr;

  assign idx       = bus.ADDRESS[4:2];
  assign off       = bus.ADDRESS[1:0];
  assign mi        = miss_addr_q[2:0];
  assign blk       = data_q[idx];
  assign sel_byte  = blk[{off, 3'b000} +: 8];
  assign req       = bus.READ | bus.WRITE;
  assign hit       = valid_q[idx] && (tag_q[idx] == bus.ADDRESS[7:5]);
  assign rd_hit    = (state_q == S_IDLE) && bus.READ && !bus.WRITE && hit;
  assign wr_hit    = (state_q == S_IDLE) && bus.WRITE && hit;
  assign miss      = (state_q == S_IDLE) && req && !hit;
  assign fill_done = (state_q == S_FETCH) && !bus.MEM_BUSYWAIT;

  // The block address is latched on the miss so a transfer already under way
  // finishes coherently even if the CPU drops or changes its request.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    mem_addr  = miss_addr_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          busy    = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        busy      = 1'b1;
        mem_addr  = {tag_q[mi], mi};
        if (!bus.MEM_BUSYWAIT) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        if (!bus.MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rdata_q     <= '0;
      miss_addr_q <= '0;
      replay_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= (state_q == S_UPDATE);
      if (miss) begin
        miss_addr_q <= bus.ADDRESS[7:2];
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if ((rd_hit || wr_hit) && !replay_q && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (rd_hit) rdata_q <= sel_byte;
      if (wr_hit) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[mi] <= 1'b1;
        dirty_q[mi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_q[mi] <= bus.MEM_READDATA;
      tag_q[mi]  <= miss_addr_q[5:3];
    end else if (wr_hit) begin
      data_q[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
    end
  end

  assign bus.READDATA      = rd_hit ? sel_byte : rdata_q;
  assign bus.BUSYWAIT      = busy & RESET;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_addr;
  assign bus.MEM_WRITEDATA = data_q[mi];
  assign HIT_COUNT         = hit_cnt_q;
  assign MISS_COUNT        = miss_cnt_q;

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a fixed-latency block memory.
module tb_dcache_direct_mapped;
  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;
  int          n_checks = 0;
  int          n_err = 0;

  dcache_direct_mapped_if bus();

  dcache_direct_mapped #(.CNT_W(16)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .bus        (bus),
    .HIT_COUNT  (hit_cnt),
    .MISS_COUNT (miss_cnt)
  );

  always #5 clk = ~clk;

  // Block memory: busy for LAT cycles per transfer, read-only contents.
  logic [31:0] mem [64];
  int          lat_cnt = 0;
  int          wb_count = 0, rd_count = 0, both_cnt = 0;
  logic [5:0]  wb_addr = '0, rd_addr = '0;
  logic [31:0] wb_data = '0;

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (lat_cnt != LAT - 1);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  always @(posedge clk) begin
    if ((bus.MEM_READ | bus.MEM_WRITE) && bus.MEM_BUSYWAIT) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
    if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
      wb_count <= wb_count + 1;
      wb_addr  <= bus.MEM_ADDRESS;
      wb_data  <= bus.MEM_WRITEDATA;
    end
    if (bus.MEM_READ && !bus.MEM_BUSYWAIT) begin
      rd_count <= rd_count + 1;
      rd_addr  <= bus.MEM_ADDRESS;
    end
    if (bus.MEM_READ && bus.MEM_WRITE) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request and waits (bounded) until BUSYWAIT is low; cyc = stall cycles.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int cyc);
    @(negedge clk);
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = wd;
    cyc = 0;
    #1;
    while (bus.BUSYWAIT === 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    #1;
  endtask

  int c;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[6'h00] = 32'h4433_2211;
    mem[6'h08] = 32'hDDCC_BBAA;
    mem[6'h01] = 32'h8765_4321;
    mem[6'h09] = 32'h0F0E_0D0C;
    bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = '0; bus.WRITEDATA = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.BUSYWAIT), 0);
    chk("rst_rdata", 32'(bus.READDATA), 0);
    chk("rst_mrd", 32'(bus.MEM_READ), 0);
    chk("rst_mwr", 32'(bus.MEM_WRITE), 0);
    chk("rst_hit", 32'(hit_cnt), 0);
    chk("rst_miss", 32'(miss_cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    // Clean miss on 0x00
    access(1'b1, 1'b0, 8'h00, 8'h00, c);
    chk("miss00_cyc", 32'(c), 7);
    chk("miss00_rdata", 32'(bus.READDATA), 32'h11);
    idle();
    chk("miss00_addr", 32'(rd_addr), 32'h00);
    chk("miss00_misscnt", 32'(miss_cnt), 1);
    chk("miss00_hitcnt", 32'(hit_cnt), 0);
    chk("miss00_nowb", 32'(wb_count), 0);

    // Read hit on 0x03
    access(1'b1, 1'b0, 8'h03, 8'h00, c);
    chk("hit03_cyc", 32'(c), 0);
    chk("hit03_rdata", 32'(bus.READDATA), 32'h44);
    idle();
    chk("hit03_hitcnt", 32'(hit_cnt), 1);
    chk("hit03_hold", 32'(bus.READDATA), 32'h44);

    // Write hit then read back
    access(1'b0, 1'b1, 8'h01, 8'hAB, c);
    chk("wr01_cyc", 32'(c), 0);
    access(1'b1, 1'b0, 8'h01, 8'h00, c);
    chk("rd01_cyc", 32'(c), 0);
    chk("rd01_rdata", 32'(bus.READDATA), 32'hAB);
    idle();
    chk("rd01_hitcnt", 32'(hit_cnt), 3);
    chk("rd01_memrd", 32'(rd_count), 1);
    chk("rd01_memwb", 32'(wb_count), 0);

    // Dirty conflict miss on 0x20
    access(1'b1, 1'b0, 8'h20, 8'h00, c);
    chk("miss20_cyc", 32'(c), 12);
    chk("miss20_rdata", 32'(bus.READDATA), 32'hAA);
    idle();
    chk("miss20_wbcnt", 32'(wb_count), 1);
    chk("miss20_wbaddr", 32'(wb_addr), 32'h00);
    chk("miss20_wbdata", wb_data, 32'h4433_AB11);
    chk("miss20_rdaddr", 32'(rd_addr), 32'h08);
    chk("miss20_misscnt", 32'(miss_cnt), 2);
    chk("miss20_hitcnt", 32'(hit_cnt), 3);

    // Reset asserted during FETCH
    @(negedge clk);
    bus.READ = 1'b1; bus.ADDRESS = 8'h00;
    @(negedge clk);
    #1;
    chk("abort_mrd_on", 32'(bus.MEM_READ), 1);
    chk("abort_mwr_off", 32'(bus.MEM_WRITE), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mrd", 32'(bus.MEM_READ), 0);
    chk("abort_busy", 32'(bus.BUSYWAIT), 0);
    chk("abort_rdata", 32'(bus.READDATA), 0);
    chk("abort_misscnt", 32'(miss_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    bus.READ = 1'b0; rst_n = 1'b1;

    access(1'b1, 1'b0, 8'h20, 8'h00, c);
    chk("rearm20_cyc", 32'(c), 7);
    chk("rearm20_rdata", 32'(bus.READDATA), 32'hAA);
    idle();
    chk("rearm20_nowb", 32'(wb_count), 1);
    chk("rearm20_memrd", 32'(rd_count), 3);
    chk("rearm20_misscnt", 32'(miss_cnt), 1);

    // READ and WRITE together: store wins
    access(1'b1, 1'b1, 8'h05, 8'h5A, c);
    chk("rw05_cyc", 32'(c), 7);
    chk("rw05_noread", 32'(bus.READDATA), 32'hAA);
    idle();
    access(1'b1, 1'b0, 8'h05, 8'h00, c);
    chk("rd05_cyc", 32'(c), 0);
    chk("rd05_rdata", 32'(bus.READDATA), 32'h5A);
    idle();
    chk("rd05_hold", 32'(bus.READDATA), 32'h5A);

    // Evict the stored block to confirm the merged write-back
    access(1'b1, 1'b0, 8'h25, 8'h00, c);
    chk("miss25_cyc", 32'(c), 12);
    chk("miss25_rdata", 32'(bus.READDATA), 32'h0D);
    idle();
    chk("miss25_wbaddr", 32'(wb_addr), 32'h01);
    chk("miss25_wbdata", wb_data, 32'h8765_5A21);
    chk("miss25_misscnt", 32'(miss_cnt), 3);
    chk("miss25_hitcnt", 32'(hit_cnt), 1);
    chk("never_both", 32'(both_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
